// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the 16-entry register file, sharing one
// decoder/write path among four requesters, plus a hardware clear sweep.
module regfile_wr_arbiter #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [3:0]    req_i,
  input  logic [3:0]    addr0_i,
  input  logic [3:0]    addr1_i,
  input  logic [3:0]    addr2_i,
  input  logic [3:0]    addr3_i,
  input  logic [DW-1:0] data0_i,
  input  logic [DW-1:0] data1_i,
  input  logic [DW-1:0] data2_i,
  input  logic [DW-1:0] data3_i,
  input  logic          clr_start_i,
  output logic [3:0]    gnt_o,
  output logic [3:0]    dec_in_o,
  output logic          dec_load_o,
  output logic [DW-1:0] wr_data_o,
  output logic          busy_o,
  output logic          clr_done_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    dec_in_q, dec_in_d;
  logic          dec_load_q, dec_load_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          clr_done_q, clr_done_d;

  logic [3:0]    eligible;
  logic          found;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          arb;
  logic [3:0]    addr_sel;
  logic [DW-1:0] data_sel;

  // The registered grant doubles as the one-cycle mask against re-granting a held request.
  assign eligible = req_i & ~gnt_q;

  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    addr_sel = addr0_i;
    data_sel = data0_i;
    case (pick)
      2'd0: begin addr_sel = addr0_i; data_sel = data0_i; end
      2'd1: begin addr_sel = addr1_i; data_sel = data1_i; end
      2'd2: begin addr_sel = addr2_i; data_sel = data2_i; end
      default: begin addr_sel = addr3_i; data_sel = data3_i; end
    endcase
  end

  // The last sweep cycle also arbitrates, so a waiting requester is granted as busy falls.
  assign arb = ((state_q == IDLE) && !clr_start_i) ||
               ((state_q == CLEAR) && (cnt_q == 4'd15));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gnt_d      = 4'b0000;
    dec_in_d   = dec_in_q;
    dec_load_d = 1'b0;
    wr_data_d  = wr_data_q;
    busy_d     = 1'b0;
    clr_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr_start_i) begin
          state_d    = CLEAR;
          cnt_d      = 4'd0;
          dec_in_d   = 4'd0;
          wr_data_d  = '0;
          dec_load_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
        end else begin
          cnt_d      = cnt_q + 4'd1;
          dec_in_d   = cnt_q + 4'd1;
          wr_data_d  = '0;
          dec_load_d = 1'b1;
          busy_d     = 1'b1;
          clr_done_d = (cnt_q == 4'd14);
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb && found) begin
      gnt_d      = 4'b0001 << pick;
      dec_in_d   = addr_sel;
      wr_data_d  = data_sel;
      dec_load_d = 1'b1;
      ptr_d      = pick + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      cnt_q      <= 4'd0;
      gnt_q      <= 4'b0000;
      dec_in_q   <= 4'd0;
      dec_load_q <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      dec_in_q   <= dec_in_d;
      dec_load_q <= dec_load_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign dec_in_o   = dec_in_q;
  assign dec_load_o = dec_load_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign clr_done_o = clr_done_q;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and sequencer for the 16-entry register file whose per-register write enables come from the 4-to-16 load decoder. It shares the single decoder/write path among four requesters with round-robin fairness. It drives the decoder select and load inputs plus the write data bus. It also provides a hardware clear sweep that zeroes all 16 registers.

## Interface
- DW, 16, write data width
- clk  in  1  rising-edge clock; the block has one clock
- reset  in  1  synchronous, active-high reset
- req  in  4  per-requester write request; bit i for requester i
- addr0..addr3  in  4 each  target register of requester i
- data0..data3  in  DW each  write data of requester i
- clr_start  in  1  one-cycle pulse that starts the clear sweep
- gnt  out  4  registered one-hot grant pulse; at most one bit set
- dec_in  out  4  register select to the decoder `in`
- dec_load  out  1  decoder `load`; one write occurs in each cycle it is high
- wr_data  out  DW  write data to the register file
- busy  out  1  high while the clear sweep runs
- clr_done  out  1  one-cycle pulse in the cycle of the last clear write

## Operation
- FSM states: IDLE, CLEAR.
- IDLE:
  - At each edge, the block picks one eligible requester. A requester is eligible if its req bit is 1 and it was not granted in the previous cycle (one-cycle mask).
  - Selection is round-robin. Priority pointer ptr (2 bits) names the highest-priority requester; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On a grant to requester i:
    - gnt[i]=1;
    - dec_in=addr_i and wr_data=data_i, both sampled at that edge;
    - dec_load=1;
    - ptr=i+1 mod 4.
  - No eligible requester: gnt=0, dec_load=0, dec_in and wr_data hold their last values, ptr unchanged.
- Requester handshake:
  - Hold req, addr and data stable until gnt[i] is seen high.
  - In the gnt cycle, drop req or present the next request. The one-cycle mask prevents a double grant of the held request.
- clr_start in IDLE wins over all requests: no grant at that edge, next state CLEAR, sweep counter = 0.
- CLEAR:
  - Each cycle: dec_in = counter, wr_data = 0, dec_load = 1, busy = 1, gnt = 0.
  - Counter runs 0..15, one write per cycle.
  - At counter 15, clr_done = 1; the next state is IDLE.
  - req is ignored and not latched; requesters keep waiting.
  - ptr is unchanged across the sweep.
  - clr_start during CLEAR is ignored.
- Counter is 4 bits; it stops at 15 and does not wrap into a second sweep.

## Timing
- Reset values:
  - gnt=0, dec_in=0, wr_data=0, dec_load=0, busy=0, clr_done=0;
  - ptr=0, previous-grant mask=0, state=IDLE, counter=0.
- Reset asserted mid-sweep aborts the sweep at the next edge: no clr_done, and the sweep does not resume.
- All outputs are registered.
- Grant latency: req sampled high at edge k gives gnt/dec_load/dec_in/wr_data valid in the cycle after edge k; the register file captures at edge k+1.
- Throughput:
  - Back-to-back writes are possible when different requesters alternate.
  - A single continuous requester gets at most one grant every 2 cycles.
- Clear sweep:
  - clr_start sampled at edge k gives busy=1 and dec_in=0 after edge k.
  - dec_in=15 with clr_done=1 after edge k+15.
  - busy=0 after edge k+16; the first grant is possible after edge k+16 if req was sampled at edge k+16.
- During all 16 sweep cycles, busy and dec_load are both 1.

## Test plan
- Reset, then req=4'b0001, addr0=5, data0=16'hABCD → one cycle later: gnt=0001, dec_in=5, wr_data=ABCD, dec_load=1; ptr becomes 1.
- req=4'b1111 held continuously with per-requester addresses 1,2,3,4 → grants in order 0,1,2,3,0,… with one grant every cycle and no gaps.
- Only req[2] held high for 6 cycles → gnt[2] is 1 every other cycle (3 grants), and dec_load matches.
- clr_start pulse in the same cycle as req=4'b0010 → no grant; 16 cycles of dec_in=0..15 with wr_data=0 and busy=1; clr_done with dec_in=15; gnt[1] in the cycle after busy falls.
- reset asserted when dec_in=7 during a sweep → next cycle all outputs are 0, no clr_done, state IDLE; a following req is granted to requester 0 first (ptr=0).
- clr_start pulsed again mid-sweep → ignored; the sweep ends after exactly 16 writes with a single clr_done.
